mac_exec_seq: RTL and testbench

Execution sequencer between the loaded A/B operand FIFOs and the MAC8 array. It runs after the memory controller reports its load complete. It clears the accumulators, streams K operand sets out of the 8 A FIFOs and the B FIFO into MAC8 with correctly aligned enables, and waits for the MAC pipeline to drain. It then captures all ROWS accumulator results and returns them one per transfer on a valid/ready result stream.

---
 rtl/mac_exec_seq.sv | 142 ++++++++++++++
 tb/tb_mac_exec_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_exec_seq.sv
// mac_exec_seq: feeds K operand sets from the A/B FIFOs into MAC8, then returns the ROWS accumulator results on a valid/ready stream.
// Optional EXEC_UNDERFLOW_GUARD_EN: stall reads while any FIFO is empty and raise a sticky underflow flag.

module mac_exec_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int ROWS         = 8,
  parameter int K            = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [ROWS-1:0]                 a_rden,
  output logic                            b_rden,
  input  logic [ROWS-1:0]                 a_empty,
  input  logic                            b_empty,
  output logic                            mac_en,
  output logic                            mac_clr,
  input  logic [ROWS*3*DATA_WIDTH-1:0]    c_in,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [3*DATA_WIDTH-1:0]         res_data,
  output logic [$clog2(ROWS)-1:0]         res_idx,
  output logic                            underflow
);

  localparam int RES_W = 3 * DATA_WIDTH;
  localparam int IDX_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(K + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [CNT_W-1:0] K_CNT     = CNT_W'(K);
  localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(ROWS - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] rd_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic [RES_W-1:0] result [ROWS];
  logic             ok;
  logic             rd_want;
  logic             rd_fire;

`ifdef EXEC_UNDERFLOW_GUARD_EN
  assign ok = ~|a_empty && ~b_empty;
`else
  logic unused_empty;
  assign ok           = 1'b1;
  assign unused_empty = ^{a_empty, b_empty};
`endif

  assign rd_want   = (state == S_RUN) && (rd_cnt < K_CNT);
  assign rd_fire   = rd_want && ok;
  assign a_rden    = {ROWS{rd_fire}};
  assign b_rden    = rd_fire;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mac_clr   = (state == S_CLEAR);
  assign res_valid = (state == S_OUT);
  assign res_data  = (state == S_OUT) ? result[res_idx] : '0;

  // mac_en trails each read by one cycle, when the FIFO data is presented to MAC8.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      mac_en    <= 1'b0;
      res_idx   <= '0;
    end else begin
      mac_en <= rd_fire;
      case (state)
        S_IDLE: begin
          if (start) state <= S_CLEAR;
        end
        S_CLEAR: begin
          rd_cnt <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
          if ((rd_cnt == K_CNT) && mac_en) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRN_LAST) state <= S_CAPTURE;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        S_CAPTURE: begin
          res_idx <= '0;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_idx <= res_idx + 1'b1;
            if (res_idx == IDX_LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) result[r] <= '0;
    end else if (state == S_CAPTURE) begin
      for (int r = 0; r < ROWS; r++) result[r] <= c_in[r*RES_W +: RES_W];
    end
  end

`ifdef EXEC_UNDERFLOW_GUARD_EN
  // Sticky until the next accepted start; set on every stalled read slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      underflow <= 1'b0;
    end else if (rd_want && !ok) begin
      underflow <= 1'b1;
    end
  end
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_mac_exec_seq.sv
// tb_mac_exec_seq: random and directed runs of mac_exec_seq against FIFO/MAC8 models, results checked against a sum-of-products reference.

module tb_mac_exec_seq;

  localparam int DW    = 8;
  localparam int ROWS  = 8;
  localparam int K     = 8;
  localparam int DRAIN = 3;
  localparam int RW    = 3 * DW;
  localparam int IW    = $clog2(ROWS);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 res_ready = 1'b0;
  logic                 busy, done, b_rden, mac_en, mac_clr, res_valid, underflow;
  logic [ROWS-1:0]      a_rden;
  logic [ROWS-1:0]      a_empty;
  logic                 b_empty;
  logic [ROWS*RW-1:0]   c_in;
  logic [RW-1:0]        res_data;
  logic [IW-1:0]        res_idx;

  mac_exec_seq #(.DATA_WIDTH(DW), .ROWS(ROWS), .K(K), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .a_rden(a_rden), .b_rden(b_rden), .a_empty(a_empty), .b_empty(b_empty),
    .mac_en(mac_en), .mac_clr(mac_clr), .c_in(c_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Operand FIFOs (data valid the cycle after a read) and the MAC8 accumulators.
  logic [DW-1:0] a_mem [ROWS][256];
  logic [DW-1:0] b_mem [256];
  int            a_wr [ROWS];
  int            a_rd [ROWS];
  int            b_wr = 0;
  int            b_rd = 0;
  logic [DW-1:0] a_data [ROWS];
  logic [DW-1:0] b_data;
  logic [RW-1:0] acc [ROWS];

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (a_rden[r] && (a_rd[r] != a_wr[r])) begin
        a_data[r] <= a_mem[r][a_rd[r]];
        a_rd[r]   <= a_rd[r] + 1;
      end
    end
    if (b_rden && (b_rd != b_wr)) begin
      b_data <= b_mem[b_rd];
      b_rd   <= b_rd + 1;
    end
    for (int r = 0; r < ROWS; r++) begin
      if (mac_clr) acc[r] <= '0;
      else if (mac_en) acc[r] <= acc[r] + RW'(a_data[r]) * RW'(b_data);
    end
  end

  always_comb begin
    a_empty = '0;
    c_in    = '0;
    for (int r = 0; r < ROWS; r++) begin
      a_empty[r]        = (a_rd[r] == a_wr[r]);
      c_in[r*RW +: RW]  = acc[r];
    end
    b_empty = (b_rd == b_wr);
  end

  // Protocol monitor: enable alignment and illegal overlaps, counted per run.
  int   mac_cnt = 0;
  int   align_err = 0;
  int   mon_err = 0;
  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    if (mac_en) mac_cnt++;
    if (mac_en != prev_rd) align_err++;
    if (mac_en && mac_clr) mon_err++;
    if ((|a_rden || b_rden) && !busy) mon_err++;
    if (a_rden != {ROWS{b_rden}}) mon_err++;
    prev_rd = b_rden;
  end

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] a_vals [ROWS][K];
  logic [DW-1:0] b_vals [K];
  logic [RW-1:0] exp_res [ROWS];
  int            b_loaded = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: A row r = r+1, B = 1; mode 1: A0 = 1..K, B = K..1; otherwise random.
  task automatic applyStimulus(input int mode, input int b_now);
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < K; k++) begin
        case (mode)
          0:       a_vals[r][k] = DW'(r + 1);
          1:       a_vals[r][k] = (r == 0) ? DW'(k + 1) : DW'($urandom_range(0, 255));
          default: a_vals[r][k] = DW'($urandom_range(0, 255));
        endcase
        a_mem[r][a_wr[r]] = a_vals[r][k];
        a_wr[r]++;
      end
    end
    for (int k = 0; k < K; k++) begin
      case (mode)
        0:       b_vals[k] = DW'(1);
        1:       b_vals[k] = DW'(K - k);
        default: b_vals[k] = DW'($urandom_range(0, 255));
      endcase
    end
    b_loaded = 0;
    while (b_loaded < b_now) begin
      b_mem[b_wr] = b_vals[b_loaded];
      b_wr++;
      b_loaded++;
    end
  endtask

  task automatic pushLateB();
    while (b_loaded < K) begin
      b_mem[b_wr] = b_vals[b_loaded];
      b_wr++;
      b_loaded++;
    end
  endtask

  // rmode 0: ready always high, 1: ready toggles, 2: random ready.
  task automatic runAndCheck(input string name, input int rmode, input int extra_start,
                             input int late_b_cyc, input bit timed);
    int cyc, n_xfer, first_valid, last_xfer, t_done, hold_err, left;
    bit timed_out;
    for (int r = 0; r < ROWS; r++) begin
      exp_res[r] = '0;
      for (int k = 0; k < K; k++) exp_res[r] += RW'(a_vals[r][k]) * RW'(b_vals[k]);
    end
    n_xfer = 0; first_valid = -1; last_xfer = -1; t_done = -1; hold_err = 0; timed_out = 0;
    @(negedge clk);
    mac_cnt = 0; align_err = 0; mon_err = 0;
    start = 1'b1;
    res_ready = (rmode == 0);
    @(negedge clk);
    cyc = 1;
    checkOutput({name, "_clr"}, mac_clr, 1);
    forever begin
      start = (cyc == extra_start);
      if (cyc == late_b_cyc) pushLateB();
      if (done) begin
        t_done = cyc;
        break;
      end
      if (cyc > 400) begin
        timed_out = 1;
        break;
      end
      if (res_valid && (first_valid < 0)) first_valid = cyc;
      case (rmode)
        0:       res_ready = 1'b1;
        1:       res_ready = (cyc % 2 == 1);
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
      if (res_valid) begin
        if (n_xfer >= ROWS) begin
          hold_err++;
        end else if (res_ready) begin
          checkOutput($sformatf("%s_idx%0d", name, n_xfer), res_idx, n_xfer);
          checkOutput($sformatf("%s_data%0d", name, n_xfer), res_data, exp_res[n_xfer]);
          n_xfer++;
          last_xfer = cyc;
        end else if ((res_idx != IW'(n_xfer)) || (res_data != exp_res[n_xfer])) begin
          hold_err++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    res_ready = 1'b0;
    left = b_wr - b_rd;
    for (int r = 0; r < ROWS; r++) left += a_wr[r] - a_rd[r];
    checkOutput({name, "_timeout"}, timed_out, 0);
    checkOutput({name, "_xfers"}, n_xfer, ROWS);
    checkOutput({name, "_mac_en_cnt"}, mac_cnt, K);
    checkOutput({name, "_en_align"}, align_err, 0);
    checkOutput({name, "_protocol"}, mon_err, 0);
    checkOutput({name, "_hold"}, hold_err, 0);
    checkOutput({name, "_done_after_last"}, t_done, last_xfer + 1);
    checkOutput({name, "_fifo_left"}, left, 0);
    if (timed) begin
      checkOutput({name, "_valid_rise"}, first_valid, K + DRAIN + 4);
      checkOutput({name, "_start_to_done"}, t_done, K + DRAIN + ROWS + 4);
    end
    @(negedge clk);
    checkOutput({name, "_idle_busy"}, busy, 0);
    checkOutput({name, "_done_pulse"}, done, 0);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_done"}, done, 0);
    checkOutput({name, "_a_rden"}, a_rden, 0);
    checkOutput({name, "_b_rden"}, b_rden, 0);
    checkOutput({name, "_mac_en"}, mac_en, 0);
    checkOutput({name, "_mac_clr"}, mac_clr, 0);
    checkOutput({name, "_res_valid"}, res_valid, 0);
    checkOutput({name, "_res_data"}, res_data, 0);
    checkOutput({name, "_res_idx"}, res_idx, 0);
    checkOutput({name, "_underflow"}, underflow, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, K);
    runAndCheck("basic", 0, -1, -1, 1'b1);
    checkOutput("basic_underflow", underflow, 0);

    applyStimulus(1, K);
    runAndCheck("mixed", 0, -1, -1, 1'b1);
    checkOutput("mixed_idx0_value", exp_res[0], 120);

    applyStimulus(0, K);
    runAndCheck("bp", 1, -1, -1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(2, K);
      runAndCheck($sformatf("rand%0d", i), 2, -1, -1, 1'b0);
    end

    applyStimulus(2, K);
    runAndCheck("start_busy", 0, 5, -1, 1'b1);

`ifdef EXEC_UNDERFLOW_GUARD_EN
    applyStimulus(0, K / 2);
    runAndCheck("guard", 0, -1, 10, 1'b0);
    checkOutput("guard_underflow", underflow, 1);
`endif

    applyStimulus(2, K);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_run_busy", busy, 1);
    checkOutput("rst_run_rden", b_rden, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetOutputs("rst_run");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_run_stay_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
